// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered N-to-1 stream mux with packet locking and rr/fixed arbitration
module stream_mux_rr #(
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_CH     = 4,
  parameter int  ARB_MODE   = 0,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH-1:0]            in_last,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W-1:0] lock_q, lock_d;
  logic [CH_W-1:0] grant;
  logic            grant_vld;
  logic [CH_W-1:0] sel;
  logic            sel_ok;
  logic            sel_last;
  logic            load_en;
  logic            xfer;
  int              cand;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Wrap a channel index to the next one, modulo NUM_CH (not necessarily a power of 2).
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    if (int'(c) == NUM_CH - 1) begin
      return '0;
    end
    return c + CH_W'(1);
  endfunction

  // The output register may take a new beat when it is empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Arbiter: search from the rr pointer (wrapping) or from index 0 in fixed-priority mode.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) begin
        cand = k;
      end else begin
        cand = int'(ptr_q) + k;
        if (cand >= NUM_CH) begin
          cand = cand - NUM_CH;
        end
      end
      if (!grant_vld && in_valid[CH_W'(cand)]) begin
        grant     = CH_W'(cand);
        grant_vld = 1'b1;
      end
    end
  end

  // Inside a packet the locked channel owns the mux even while it is idle.
  assign sel      = (state_q == LOCKED) ? lock_q : grant;
  assign sel_ok   = (state_q == LOCKED) || grant_vld;
  assign sel_last = in_last[sel];
  assign xfer     = |(in_valid & in_ready);

  // State register: lock owner, rr pointer and IDLE/LOCKED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: enter LOCKED on a non-final beat, leave it on the final beat and rotate the pointer.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        if (sel_last) begin
          ptr_d = next_ch(sel);
        end else begin
          state_d = LOCKED;
          lock_d  = sel;
        end
      end else if (sel_last) begin
        state_d = IDLE;
        ptr_d   = next_ch(lock_q);
      end
    end
  end

  // Outputs: one-hot ready to the selected channel, gated by output space and held low in reset.
  always_comb begin
    in_ready = '0;
    if (!reset && sel_ok && load_en) begin
      in_ready[sel] = 1'b1;
    end
  end

  // Output register: refill on load_en, keep payload stable while stalled or empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= ch_data[sel];
        out_last <= sel_last;
        out_ch   <= sel;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (rr and fixed-priority instances)
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int ch;
    int data;
    int last;
    int cyc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   iv   [2];
  logic [N-1:0]   il   [2];
  logic [N*W-1:0] idt  [2];
  logic           ordy [2];

  logic [N-1:0] ir0, ir1;
  logic [W-1:0] od0, od1;
  logic         ol0, ol1, ov0, ov1;
  logic [1:0]   oc0, oc1;

  stream_mux_rr #(.DATA_WIDTH(W), .NUM_CH(N), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .in_data(idt[0]), .in_valid(iv[0]), .in_last(il[0]), .in_ready(ir0),
    .out_data(od0), .out_last(ol0), .out_ch(oc0), .out_valid(ov0), .out_ready(ordy[0])
  );

  stream_mux_rr #(.DATA_WIDTH(W), .NUM_CH(N), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .in_data(idt[1]), .in_valid(iv[1]), .in_last(il[1]), .in_ready(ir1),
    .out_data(od1), .out_last(ol1), .out_ch(oc1), .out_valid(ov1), .out_ready(ordy[1])
  );

  beat_t srcq [2][N][$];
  obs_t  olog [2][$];
  bit    en   [2][N];

  int m_lock [2];
  int m_ptr  [2];
  int m_ov   [2];
  int m_od   [2];
  int m_ol   [2];
  int m_oc   [2];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int first_pop [2];
  int watch_hits = 0;
  bit watch = 1'b0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input int d, input int ch, input int data, input int last);
    beat_t b;
    b.data = W'(data);
    b.last = (last != 0);
    srcq[d][ch].push_back(b);
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        srcq[d][i].delete();
        en[d][i] = 1'b0;
      end
      olog[d].delete();
      first_pop[d] = -1;
      ordy[d] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lock[d] = -1;
      m_ptr[d]  = 0;
      m_ov[d]   = 0;
      m_od[d]   = 0;
      m_ol[d]   = 0;
      m_oc[d]   = 0;
    end
  endtask

  // Channel the arbiter would pick in IDLE: instance 0 is round-robin, instance 1 fixed priority.
  function automatic int pick(input int d);
    int c;
    for (int k = 0; k < N; k++) begin
      c = (d == 1) ? k : (m_ptr[d] + k) % N;
      if (iv[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int d);
    int g;
    if (reset) return 0;
    if (m_ov[d] != 0 && !ordy[d]) return 0;
    if (m_lock[d] >= 0) return 1 << m_lock[d];
    g = pick(d);
    if (g < 0) return 0;
    return 1 << g;
  endfunction

  task automatic model_step(input int d);
    int t;
    bit load;
    bit x;
    load = (m_ov[d] == 0) || ordy[d];
    t = (m_lock[d] >= 0) ? m_lock[d] : pick(d);
    x = load && (t >= 0) && iv[d][t];
    if (load) m_ov[d] = x;
    if (x) begin
      m_od[d] = int'(idt[d][t*W +: W]);
      m_ol[d] = int'(il[d][t]);
      m_oc[d] = t;
      if (m_lock[d] < 0) begin
        if (il[d][t]) m_ptr[d] = (t + 1) % N;
        else m_lock[d] = t;
      end else if (il[d][t]) begin
        m_lock[d] = -1;
        m_ptr[d]  = (t + 1) % N;
      end
    end
  endtask

  // One clock: drive at negedge, check #1 later, advance model and sources at posedge.
  task automatic cycle();
    logic [N-1:0] rs [2];
    logic [W-1:0] od;
    logic         ol, ov;
    logic [1:0]   oc;
    obs_t         o;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        iv[d][i] = en[d][i] && (srcq[d][i].size() > 0);
        if (srcq[d][i].size() > 0) begin
          idt[d][i*W +: W] = srcq[d][i][0].data;
          il[d][i] = srcq[d][i][0].last;
        end else begin
          idt[d][i*W +: W] = W'($urandom);
          il[d][i] = 1'($urandom);
        end
      end
    end
    #1;
    if (reset) model_reset();
    for (int d = 0; d < 2; d++) begin
      rs[d] = (d == 0) ? ir0 : ir1;
      od = (d == 0) ? od0 : od1;
      ol = (d == 0) ? ol0 : ol1;
      ov = (d == 0) ? ov0 : ov1;
      oc = (d == 0) ? oc0 : oc1;
      check($sformatf("d%0d in_ready c%0d", d, cyc), int'(rs[d]), exp_ready(d));
      check($sformatf("d%0d out_valid c%0d", d, cyc), int'(ov), m_ov[d]);
      check($sformatf("d%0d out_data c%0d", d, cyc), int'(od), m_od[d]);
      check($sformatf("d%0d out_last c%0d", d, cyc), int'(ol), m_ol[d]);
      check($sformatf("d%0d out_ch c%0d", d, cyc), int'(oc), m_oc[d]);
      if (ov && ordy[d] && !reset) begin
        o.ch = int'(oc); o.data = int'(od); o.last = int'(ol); o.cyc = cyc;
        olog[d].push_back(o);
      end
    end
    if (watch && ir0[0]) watch_hits++;
    @(posedge clk);
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        model_step(d);
        for (int i = 0; i < N; i++) begin
          if (iv[d][i] && rs[d][i]) begin
            void'(srcq[d][i].pop_front());
            if (first_pop[d] < 0) first_pop[d] = cyc;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input string tag, input int d, input int n, input int budget);
    for (int k = 0; k < budget && olog[d].size() < n; k++) cycle();
    check(tag, olog[d].size(), n);
  endtask

  function automatic int lch(input int d, input int k);
    return (k < olog[d].size()) ? olog[d][k].ch : -1;
  endfunction

  function automatic int ldat(input int d, input int k);
    return (k < olog[d].size()) ? olog[d][k].data : -1;
  endfunction

  function automatic int lcyc(input int d, input int k);
    return (k < olog[d].size()) ? olog[d][k].cyc : -1;
  endfunction

  initial begin
    int cnt;
    for (int d = 0; d < 2; d++) begin
      iv[d] = '0; il[d] = '0; idt[d] = '0;
    end
    clear_all();
    model_reset();
    reset = 1'b1;
    @(negedge clk);

    // Reset holds everything quiet even with valid sources.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        push(d, i, 'h70 + i, 1);
        en[d][i] = 1'b1;
      end
    repeat (3) cycle();
    check("reset in_ready", int'(ir0), 0);
    check("reset out_valid", int'(ov0), 0);
    check("reset out_data", int'(od0), 0);
    check("reset out_ch", int'(oc0), 0);
    clear_all();
    reset = 1'b0;
    repeat (2) cycle();

    // Round-robin fairness with single-beat packets.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(0, i, 'h10 + i, 1);
    for (int i = 0; i < N; i++) en[0][i] = 1'b1;
    run_until("rr count", 0, 8, 40);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr ch %0d", k), lch(0, k), k % N);
      check($sformatf("rr data %0d", k), ldat(0, k), 'h10 + k % N);
    end
    check("rr latency", lcyc(0, 0), first_pop[0] + 1);
    check("rr back-to-back", lcyc(0, 5), lcyc(0, 0) + 5);
    repeat (2) cycle();

    // Packet lock: ch1 three-beat packet while ch0 keeps requesting.
    clear_all();
    push(0, 1, 'hA1, 0); push(0, 1, 'hA2, 0); push(0, 1, 'hA3, 1);
    push(0, 0, 'h01, 1); push(0, 0, 'h02, 1);
    en[0][1] = 1'b1;
    cycle();
    en[0][0] = 1'b1;
    watch = 1'b1; watch_hits = 0;
    for (int k = 0; k < 20 && srcq[0][1].size() > 0; k++) cycle();
    watch = 1'b0;
    check("lock ch0 ready", watch_hits, 0);
    run_until("lock count", 0, 5, 20);
    check("lock ch b0", lch(0, 0), 1); check("lock d b0", ldat(0, 0), 'hA1);
    check("lock ch b1", lch(0, 1), 1); check("lock d b1", ldat(0, 1), 'hA2);
    check("lock ch b2", lch(0, 2), 1); check("lock d b2", ldat(0, 2), 'hA3);
    check("lock ch b3", lch(0, 3), 0); check("lock d b3", ldat(0, 3), 'h01);
    repeat (2) cycle();

    // Backpressure: hold 0x33 for 4 stalled cycles.
    clear_all();
    push(0, 2, 'h33, 1); push(0, 2, 'h34, 1);
    ordy[0] = 1'b0;
    en[0][2] = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp data %0d", k), int'(od0), 'h33);
      check($sformatf("bp ready %0d", k), int'(ir0), 0);
      cycle();
    end
    ordy[0] = 1'b1;
    run_until("bp count", 0, 2, 20);
    repeat (3) cycle();
    check("bp no dup", olog[0].size(), 2);
    check("bp d0", ldat(0, 0), 'h33);
    check("bp d1", ldat(0, 1), 'h34);

    // Fixed priority on the second instance.
    clear_all();
    push(1, 3, 'h31, 1); push(1, 1, 'h11, 1);
    en[1][1] = 1'b1; en[1][3] = 1'b1;
    run_until("fp count", 1, 2, 20);
    check("fp first", lch(1, 0), 1);
    check("fp second", lch(1, 1), 3);
    clear_all();
    for (int k = 0; k < 10; k++) push(1, 1, 'h40 + k, 1);
    push(1, 3, 'h3F, 1);
    en[1][1] = 1'b1; en[1][3] = 1'b1;
    repeat (8) cycle();
    cnt = 0;
    foreach (olog[1][k]) if (olog[1][k].ch == 3) cnt++;
    check("fp starve", cnt, 0);
    check("fp progress", olog[1].size(), 7);
    run_until("fp drain", 1, 11, 20);
    check("fp tail ch", lch(1, 10), 3);
    check("fp tail data", ldat(1, 10), 'h3F);

    // Mid-packet gap: ch2 idles for 2 cycles while ch0 waits.
    clear_all();
    push(0, 2, 'hC1, 0); push(0, 2, 'hC2, 0); push(0, 2, 'hC3, 1);
    push(0, 0, 'h05, 1); push(0, 0, 'h06, 1);
    en[0][2] = 1'b1;
    cycle();
    en[0][2] = 1'b0; en[0][0] = 1'b1;
    watch = 1'b1; watch_hits = 0;
    cycle(); cycle();
    en[0][2] = 1'b1;
    for (int k = 0; k < 20 && srcq[0][2].size() > 0; k++) cycle();
    watch = 1'b0;
    check("gap ch0 ready", watch_hits, 0);
    run_until("gap count", 0, 5, 20);
    check("gap ch b0", lch(0, 0), 2); check("gap d b0", ldat(0, 0), 'hC1);
    check("gap ch b1", lch(0, 1), 2); check("gap d b1", ldat(0, 1), 'hC2);
    check("gap ch b2", lch(0, 2), 2); check("gap d b2", ldat(0, 2), 'hC3);
    check("gap ch b3", lch(0, 3), 0); check("gap d b3", ldat(0, 3), 'h05);

    // Reset while locked with a pending output beat.
    clear_all();
    for (int k = 0; k < 4; k++) push(0, 1, 'h61 + k, (k == 3) ? 1 : 0);
    en[0][1] = 1'b1;
    cycle();
    ordy[0] = 1'b0;
    cycle();
    check("pre-reset valid", int'(ov0), 1);
    reset = 1'b1;
    #1;
    check("mid reset valid", int'(ov0), 0);
    check("mid reset data", int'(od0), 0);
    check("mid reset ready", int'(ir0), 0);
    cycle();
    clear_all();
    cycle();
    reset = 1'b0;
    push(0, 2, 'h5A, 1);
    en[0][2] = 1'b1;
    run_until("post reset count", 0, 1, 20);
    check("post reset ch", lch(0, 0), 2);
    check("post reset data", ldat(0, 0), 'h5A);
    repeat (2) cycle();

    // Randomized traffic and backpressure against the reference model.
    clear_all();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (srcq[d][i].size() < 3 && $urandom_range(0, 3) == 0) begin
            int len;
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) push(d, i, int'($urandom_range(0, 255)), (k == len - 1) ? 1 : 0);
          end
          en[d][i] = ($urandom_range(0, 3) != 0);
        end
        ordy[d] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Registered N-to-1 stream multiplexer with valid/ready handshakes, packet locking and selectable arbitration.
- Parametrised successor of the team's combinational 2:1 mux. Channel selection is made internally by an arbiter instead of an external sel.
- Merges NUM_CH independent source streams into one output stream, e.g. multiple shifter/datapath result streams onto one shared sink.
- Output is fully registered; one beat per cycle sustained throughput.

Parameters:
- DATA_WIDTH, 8, payload width per channel (>=1).
- NUM_CH, 4, number of input channels (>=2).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- CH_W, $clog2(NUM_CH), width of the channel-index output (localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_CH*DATA_WIDTH  flattened payloads; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_CH  per-channel beat valid.
- in_last  in  NUM_CH  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  out  NUM_CH  per-channel accept; at most one bit high per cycle.
- out_data  out  DATA_WIDTH  registered payload.
- out_last  out  1  registered end-of-packet flag.
- out_ch  out  CH_W  index of the source channel of the current out beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accept.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, rr pointer=0. in_ready=0 while reset is high.
- Transfer rules:
  - An input transfer occurs on a channel when in_valid[i] and in_ready[i] are both high at a clk edge.
  - An output transfer occurs when out_valid and out_ready are both high.
- load_en = !out_valid || out_ready. The output register loads only when load_en is high; otherwise out_* hold stable.
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. valid in cycle N+1. Back-to-back beats are allowed with no bubble while out_ready stays high.
- State IDLE:
  - Grant g is selected from in_valid.
  - RR mode: first valid channel searching ptr, ptr+1, ... wrapping NUM_CH-1 to 0.
  - Fixed mode: lowest valid index.
  - in_ready[g] = load_en; all other bits 0.
  - On transfer: load out_* with channel g's data and last, and out_ch=g.
  - If in_last[g]=1: stay IDLE, ptr=(g+1) mod NUM_CH. Otherwise go to LOCKED with lock_ch=g.
  - No valid input: in_ready=0, state unchanged.
- State LOCKED:
  - in_ready[lock_ch] = load_en; all others 0.
  - Other channels are never granted mid-packet, even if lock_ch drops in_valid. The mux stalls and waits.
  - On transfer with in_last=1: go to IDLE, ptr=(lock_ch+1) mod NUM_CH (RR mode; ptr is unused in fixed mode).
- Combinational path: in_ready depends on in_valid (arbitration) and on out_valid/out_ready. No combinational path from in_data to out_*.
- Single-beat packet (in_last=1 on the first beat) never enters LOCKED.
- Output stall: while out_valid=1 and out_ready=0, in_ready is all zero and out_* are stable.
- Reset mid-packet:
  - The lock is dropped and the pending output beat is discarded.
  - After release the mux starts in IDLE with ptr=0.
- in_last/in_data on non-granted channels are ignored.
- Out-of-range index arithmetic wraps modulo NUM_CH (NUM_CH need not be a power of 2).

Test Plan:
- Reset mid-stream: assert reset while out_valid=1 and state=LOCKED -> outputs immediately 0, in_ready=0. After release, a ch2 single beat 0x5A is accepted and out_ch=2.
- RR fairness, NUM_CH=4, ARB_MODE=0: all channels continuously valid with single-beat packets (data=0x10+i), out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with matching data, one beat per cycle, first out_valid one cycle after the first accept.
- Packet lock: ch1 sends 3 beats (A1,A2,A3, last on A3) while ch0 is continuously valid -> output is A1,A2,A3 from ch1 contiguously. Ch0's first beat follows A3, and in_ready[0]=0 throughout ch1's packet.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 (data 0x33) -> out_data stays 0x33, in_ready=0 for those cycles. When out_ready rises, the next beat loads with no loss or duplication.
- Fixed priority, ARB_MODE=1: ch3 and ch1 both valid single-beat -> ch1 served first, then ch3. With ch1 continuously valid, ch3 is never served.
- Mid-packet gap: ch2 in LOCKED drops in_valid for 2 cycles while ch0 is valid -> no grant to ch0. Ch2 resumes, then ch0 is served after ch2's last beat.
